commit_trace_buffer: RTL and testbench

- Synthesizable commit-trace capture block, directly downstream of the processor's writeback/memory commit signals.
- Classifies each committed instruction into a trace record, numbers it, and buffers it in a small FIFO drained through a valid/ready port.
- Keeps instruction and cycle counters and detects halt so on-chip or emulation harnesses get the same per-instruction trace as simulation.

---
 rtl/commit_trace_buffer_pkg.sv | 84 ++++++++
 rtl/commit_trace_buffer_if.sv | 48 ++++
 rtl/commit_trace_buffer_trace_fifo.sv | 53 +++++
 rtl/commit_trace_buffer.sv | 126 ++++++++++++
 tb/tb_commit_trace_buffer.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_trace_buffer_pkg.sv
// Shared types for the commit-trace buffer: record kinds, FSM states and the packed record layout.
// The instruction number travels beside rec_t because its width is a block parameter.
package commit_trace_buffer_pkg;

  localparam int PC_W   = 16;
  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam int KIND_W = 3;

  typedef enum logic [KIND_W-1:0] {
    KIND_NOP  = 3'd0,
    KIND_REG  = 3'd1,
    KIND_LD   = 3'd2,
    KIND_ST   = 3'd3,
    KIND_STU  = 3'd4,
    KIND_HALT = 3'd5
  } kind_e;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_HALT_DRAIN = 2'd1,
    ST_DONE       = 2'd2
  } state_e;

  typedef struct packed {
    kind_e             kind;
    logic [PC_W-1:0]   pc;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] mdata;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  function automatic kind_e classify(input logic halt, input logic reg_write,
                                     input logic mem_read, input logic mem_write);
    kind_e k;
    if (halt)                        k = KIND_HALT;
    else if (reg_write && mem_write) k = KIND_STU;
    else if (reg_write && mem_read)  k = KIND_LD;
    else if (reg_write)              k = KIND_REG;
    else if (mem_write)              k = KIND_ST;
    else                             k = KIND_NOP;
    return k;
  endfunction

  // Fields a kind does not use are zeroed so the trace compares cleanly against a golden log.
  function automatic rec_t build_rec(input logic halt, input logic reg_write,
                                     input logic mem_read, input logic mem_write,
                                     input logic [PC_W-1:0] pc, input logic [REG_W-1:0] rd,
                                     input logic [DATA_W-1:0] wdata,
                                     input logic [DATA_W-1:0] addr,
                                     input logic [DATA_W-1:0] mdata);
    rec_t r;
    r      = '0;
    r.kind = classify(halt, reg_write, mem_read, mem_write);
    r.pc   = pc;
    case (r.kind)
      KIND_REG: begin
        r.rd    = rd;
        r.wdata = wdata;
      end
      KIND_LD: begin
        r.rd    = rd;
        r.wdata = wdata;
        r.addr  = addr;
      end
      KIND_ST: begin
        r.addr  = addr;
        r.mdata = mdata;
      end
      KIND_STU: begin
        r.rd    = rd;
        r.wdata = wdata;
        r.addr  = addr;
        r.mdata = mdata;
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Commit-side inputs, record drain port and status of the trace buffer.
// master = core/consumer side, slave = trace buffer.
interface commit_trace_buffer_if #(
  parameter int CNT_W = 32
);
  import commit_trace_buffer_pkg::*;

  logic              commit_valid;
  logic [PC_W-1:0]   commit_pc;
  logic              reg_write;
  logic [REG_W-1:0]  write_reg;
  logic [DATA_W-1:0] write_data;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              halt;

  logic              rec_valid;
  logic              rec_ready;
  logic [KIND_W-1:0] rec_kind;
  logic [CNT_W-1:0]  rec_inum;
  logic [PC_W-1:0]   rec_pc;
  logic [REG_W-1:0]  rec_reg;
  logic [DATA_W-1:0] rec_wdata;
  logic [DATA_W-1:0] rec_addr;
  logic [DATA_W-1:0] rec_mdata;

  logic [CNT_W-1:0]  inst_count;
  logic [CNT_W-1:0]  cycle_count;
  logic              overflow;
  logic              done;

  modport master (
    output commit_valid, commit_pc, reg_write, write_reg, write_data,
           mem_read, mem_write, mem_addr, mem_data, halt, rec_ready,
    input  rec_valid, rec_kind, rec_inum, rec_pc, rec_reg, rec_wdata,
           rec_addr, rec_mdata, inst_count, cycle_count, overflow, done
  );

  modport slave (
    input  commit_valid, commit_pc, reg_write, write_reg, write_data,
           mem_read, mem_write, mem_addr, mem_data, halt, rec_ready,
    output rec_valid, rec_kind, rec_inum, rec_pc, rec_reg, rec_wdata,
           rec_addr, rec_mdata, inst_count, cycle_count, overflow, done
  );

endinterface

// File: rtl/commit_trace_buffer_trace_fifo.sv
// Synchronous FIFO with first-word-fall-through head; push when full is accepted only if a pop
// happens in the same cycle, otherwise it is refused.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_ptr_d  = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d  = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Classifies each committed instruction into a numbered trace record and queues it for a
// valid/ready consumer; record visible one cycle after commit, dropped (sticky overflow) when full.
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  commit_trace_buffer_if.slave  bus
);

  localparam int           FIFO_W  = CNT_W + REC_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   inst_q, inst_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic               ovf_q, ovf_d;

  logic               cnt_en;
  logic               done_w;
  logic               push, pop, drop;
  logic               fifo_full, fifo_empty;
  rec_t               new_rec, head_rec;
  logic [CNT_W-1:0]   head_inum;
  logic [FIFO_W-1:0]  push_dat, head_dat;

  assign push = (state_q == ST_RUN) && bus.commit_valid;
  assign pop  = !fifo_empty && bus.rec_ready;
  // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
  assign drop = push && fifo_full && !pop;

  assign new_rec  = build_rec(bus.halt, bus.reg_write, bus.mem_read, bus.mem_write,
                              bus.commit_pc, bus.write_reg, bus.write_data,
                              bus.mem_addr, bus.mem_data);
  assign push_dat = {inst_q, new_rec};

  trace_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_trace_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push && !drop),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .pop_dat_o  (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign {head_inum, head_rec} = head_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A halt record moves to drain even when it was dropped for lack of space.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (push && bus.halt) state_d = ST_HALT_DRAIN;
      end
      ST_HALT_DRAIN: begin
        if (fifo_empty) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    cnt_en = 1'b0;
    done_w = 1'b0;
    case (state_q)
      ST_RUN, ST_HALT_DRAIN: cnt_en = 1'b1;
      ST_DONE:               done_w = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    inst_d = inst_q;
    cyc_d  = cyc_q;
    ovf_d  = ovf_q;
    if (push && (inst_q != CNT_MAX)) inst_d = inst_q + CNT_ONE;
    if (cnt_en && (cyc_q != CNT_MAX)) cyc_d = cyc_q + CNT_ONE;
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q <= '0;
      cyc_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      inst_q <= inst_d;
      cyc_q  <= cyc_d;
      ovf_q  <= ovf_d;
    end
  end

  // Record fields read as zero whenever nothing is buffered.
  assign bus.rec_valid   = !fifo_empty;
  assign bus.rec_kind    = fifo_empty ? '0 : head_rec.kind;
  assign bus.rec_inum    = fifo_empty ? '0 : head_inum;
  assign bus.rec_pc      = fifo_empty ? '0 : head_rec.pc;
  assign bus.rec_reg     = fifo_empty ? '0 : head_rec.rd;
  assign bus.rec_wdata   = fifo_empty ? '0 : head_rec.wdata;
  assign bus.rec_addr    = fifo_empty ? '0 : head_rec.addr;
  assign bus.rec_mdata   = fifo_empty ? '0 : head_rec.mdata;

  assign bus.inst_count  = inst_q;
  assign bus.cycle_count = cyc_q;
  assign bus.overflow    = ovf_q;
  assign bus.done        = done_w;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: directed scenarios plus random traffic against a queue model.
module tb_commit_trace_buffer;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  commit_trace_buffer_if #(.CNT_W(CNT_W)) bus ();

  commit_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [2:0]  rd;
    logic [15:0] wdata;
    logic [15:0] addr;
    logic [15:0] mdata;
  } mrec_t;

  // Reference model: unbounded queue capped at DEPTH, plain counters, phase 0=run 1=drain 2=done.
  mrec_t       mq[$];
  logic [31:0] m_inst;
  logic [31:0] m_cyc;
  logic        m_ovf;
  int          m_phase;

  int total;
  int bad;

  function automatic mrec_t model_rec();
    mrec_t r;
    r      = '0;
    r.inum = m_inst;
    r.pc   = bus.commit_pc;
    if (bus.halt)                            r.kind = 3'd5;
    else if (bus.reg_write && bus.mem_write) r.kind = 3'd4;
    else if (bus.reg_write && bus.mem_read)  r.kind = 3'd2;
    else if (bus.reg_write)                  r.kind = 3'd1;
    else if (bus.mem_write)                  r.kind = 3'd3;
    else                                     r.kind = 3'd0;
    if (r.kind == 3'd1 || r.kind == 3'd2 || r.kind == 3'd4) begin
      r.rd    = bus.write_reg;
      r.wdata = bus.write_data;
    end
    if (r.kind == 3'd2 || r.kind == 3'd3 || r.kind == 3'd4) r.addr = bus.mem_addr;
    if (r.kind == 3'd3 || r.kind == 3'd4) r.mdata = bus.mem_data;
    return r;
  endfunction

  function automatic logic [102:0] exp_vec();
    if (mq.size() > 0) return {1'b1, mq[0]};
    return '0;
  endfunction

  function automatic logic [102:0] obs_vec();
    return {bus.rec_valid, bus.rec_kind, bus.rec_inum, bus.rec_pc, bus.rec_reg,
            bus.rec_wdata, bus.rec_addr, bus.rec_mdata};
  endfunction

  function automatic logic [65:0] exp_stat();
    return {m_inst, m_cyc, m_ovf, (m_phase == 2)};
  endfunction

  function automatic logic [65:0] obs_stat();
    return {bus.inst_count, bus.cycle_count, bus.overflow, bus.done};
  endfunction

  task automatic model_clear();
    mq.delete();
    m_inst  = '0;
    m_cyc   = '0;
    m_ovf   = 1'b0;
    m_phase = 0;
  endtask

  task automatic model_step();
    bit    pop;
    mrec_t r;
    if (m_phase == 2) return;
    pop = (mq.size() > 0) && bus.rec_ready;
    if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
    if (m_phase == 0 && bus.commit_valid) begin
      r = model_rec();
      if (pop) mq.delete(0);
      if (mq.size() < DEPTH) mq.push_back(r);
      else m_ovf = 1'b1;
      if (m_inst != 32'hFFFF_FFFF) m_inst++;
      if (bus.halt) m_phase = 1;
    end else begin
      if (m_phase == 1 && mq.size() == 0) m_phase = 2;
      if (pop) mq.delete(0);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] pc, input logic rw,
                       input logic [2:0] rd, input logic [15:0] wd, input logic mr,
                       input logic mw, input logic [15:0] addr, input logic [15:0] md,
                       input logic h);
    bus.commit_valid = v;
    bus.commit_pc    = pc;
    bus.reg_write    = rw;
    bus.write_reg    = rd;
    bus.write_data   = wd;
    bus.mem_read     = mr;
    bus.mem_write    = mw;
    bus.mem_addr     = addr;
    bus.mem_data     = md;
    bus.halt         = h;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    bus.rec_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    idle();
    bus.rec_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (obs_vec() !== 103'd0) begin
      bad++;
      $display("FAIL reset_rec got=%h exp=0", obs_vec());
    end
    total++;
    if (obs_stat() !== 66'd0) begin
      bad++;
      $display("FAIL reset_stat got=%h exp=0", obs_stat());
    end
    rst = 1'b0;
    model_clear();
    tick();
    total++;
    if (obs_stat() !== exp_stat()) begin
      bad++;
      $display("FAIL reset_first_cycle got=%h exp=%h", obs_stat(), exp_stat());
    end
  endtask

  task automatic test_reg();
    bus.rec_ready = 1'b1;
    drive(1'b1, 16'h0000, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 16'hAAAA, 16'hBBBB, 1'b0);
    tick();
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL reg_rec got=%h exp=%h", obs_vec(), exp_vec());
    end
    total++;
    if ({bus.rec_valid, bus.rec_kind, bus.rec_inum, bus.rec_reg, bus.rec_wdata, bus.inst_count}
        !== {1'b1, 3'd1, 32'd0, 3'd3, 16'h1234, 32'd1}) begin
      bad++;
      $display("FAIL reg_fields got kind=%0d inum=%0d reg=%0d wdata=%h icnt=%0d exp 1 0 3 1234 1",
               bus.rec_kind, bus.rec_inum, bus.rec_reg, bus.rec_wdata, bus.inst_count);
    end
  endtask

  task automatic test_sequence();
    logic [2:0] kinds [4];
    kinds[0] = 3'd2; kinds[1] = 3'd3; kinds[2] = 3'd4; kinds[3] = 3'd0;
    bus.rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(1'b1, 16'h0002, 1'b1, 3'd1, 16'h00AA, 1'b1, 1'b0, 16'h0010, 16'hCCCC, 1'b0);
        1: drive(1'b1, 16'h0004, 1'b0, 3'd2, 16'h9999, 1'b0, 1'b1, 16'h0012, 16'h5555, 1'b0);
        2: drive(1'b1, 16'h0006, 1'b1, 3'd5, 16'hBEEF, 1'b1, 1'b1, 16'h0014, 16'h7777, 1'b0);
        default: drive(1'b1, 16'h0008, 1'b0, 3'd7, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
      endcase
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL seq_rec%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      total++;
      if (bus.rec_kind !== kinds[i] || bus.rec_inum !== 32'(i + 1)) begin
        bad++;
        $display("FAIL seq_kind%0d got kind=%0d inum=%0d exp kind=%0d inum=%0d",
                 i, bus.rec_kind, bus.rec_inum, kinds[i], i + 1);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'(i * 2), 1'b1, 3'(i), 16'($urandom), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      tick();
    end
    idle();
    total++;
    if (obs_stat() !== exp_stat() || bus.overflow !== 1'b1 || bus.inst_count !== 32'd10) begin
      bad++;
      $display("FAIL ovf_stat got=%h exp=%h (ovf=1 icnt=10)", obs_stat(), exp_stat());
    end
    bus.rec_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (obs_vec() !== exp_vec() || bus.rec_inum !== 32'(i)) begin
        bad++;
        $display("FAIL ovf_drain%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      tick();
    end
    total++;
    if (bus.rec_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL ovf_empty got valid=%b exp valid=0", bus.rec_valid);
    end
  endtask

  task automatic test_full_pushpop();
    int n;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 16'(i), 1'b1, 3'd1, 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      tick();
    end
    bus.rec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 16'(16'h100 + i), 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 16'(i), 16'($urandom), 1'b0);
      tick();
      total++;
      if (obs_vec() !== exp_vec() || obs_stat() !== exp_stat() || bus.overflow !== 1'b0) begin
        bad++;
        $display("FAIL fullpp%0d got=%h/%h exp=%h/%h", i, obs_vec(), obs_stat(), exp_vec(), exp_stat());
      end
    end
    idle();
    n = 0;
    for (int i = 0; i < 20 && bus.rec_valid === 1'b1; i++) begin
      n++;
      tick();
    end
    total++;
    if (n != DEPTH) begin
      bad++;
      $display("FAIL fullpp_occupancy got=%0d exp=%0d", n, DEPTH);
    end
  endtask

  task automatic test_halt();
    bit seen;
    do_reset();
    drive(1'b1, 16'h0010, 1'b1, 3'd1, 16'h0011, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    drive(1'b1, 16'h0012, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 16'h0040, 16'h4444, 1'b0);
    tick();
    drive(1'b1, 16'h0020, 1'b1, 3'd6, 16'h6666, 1'b0, 1'b1, 16'h0050, 16'h5555, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(16'h0030 + i), 1'b1, 3'd2, 16'h2222, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      tick();
    end
    idle();
    total++;
    if (obs_stat() !== exp_stat() || bus.inst_count !== 32'd3) begin
      bad++;
      $display("FAIL halt_frozen got=%h exp=%h (icnt=3)", obs_stat(), exp_stat());
    end
    bus.rec_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      total++;
      if (obs_vec() !== exp_vec() || obs_stat() !== exp_stat()) begin
        bad++;
        $display("FAIL halt_drain%0d got=%h/%h exp=%h/%h", i, obs_vec(), obs_stat(), exp_vec(), exp_stat());
      end
      if (bus.done === 1'b1) seen = 1'b1;
      else tick();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL halt_done_timeout got done=%b exp done=1", bus.done);
    end
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (obs_stat() !== exp_stat() || bus.done !== 1'b1) begin
      bad++;
      $display("FAIL halt_cycle_stop got=%h exp=%h", obs_stat(), exp_stat());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'(i), 1'b1, 3'd4, 16'($urandom), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      tick();
    end
    idle();
    total++;
    if (obs_stat() !== exp_stat() || obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL midrst_pre got=%h exp=%h", obs_stat(), exp_stat());
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.rec_valid !== 1'b0 || obs_stat() !== 66'd0 || obs_vec() !== 103'd0) begin
      bad++;
      $display("FAIL midrst_clear got valid=%b stat=%h exp 0", bus.rec_valid, obs_stat());
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_random();
    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        drive($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom), 3'($urandom),
              16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
              $urandom_range(0, 120) == 0);
        bus.rec_ready = (round == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        tick();
        total++;
        if (obs_vec() !== exp_vec() || obs_stat() !== exp_stat()) begin
          bad++;
          $display("FAIL rand_r%0d_c%0d got=%h/%h exp=%h/%h", round, c,
                   obs_vec(), obs_stat(), exp_vec(), exp_stat());
        end
      end
    end
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    bus.rec_ready = 1'b0;
    model_clear();
    test_reset();
    test_reg();
    test_sequence();
    test_overflow();
    test_full_pushpop();
    test_halt();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
